// File: rtl/measure_sequencer.sv
// Measurement scheduler: walks detect -> lock -> gain -> settle -> capture,
// with per-state timeouts, stability-loss recapture and MCU-readable status.
module measure_sequencer #(
    parameter int              CNT_W         = 24,
    parameter logic [CNT_W-1:0] LOCK_TIMEOUT  = CNT_W'(2_000_000),
    parameter logic [CNT_W-1:0] SETTLE_CYCLES = CNT_W'(4096),
    parameter logic [CNT_W-1:0] CAP_TIMEOUT   = CNT_W'(8_000_000),
    parameter int              MAX_RETRY     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       freq_det_stable,
    input  logic       freq_stable,
    input  logic       gain_stable,
    input  logic       cap_done,
    output logic       cap_start,
    output logic       busy,
    output logic       done,
    output logic [2:0] err_code,
    output logic [2:0] state_o,
    output logic [1:0] retry_cnt
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DET  = 3'd1,
        WAIT_LOCK = 3'd2,
        WAIT_GAIN = 3'd3,
        SETTLE    = 3'd4,
        CAPTURE   = 3'd5,
        DONE      = 3'd6,
        ERROR     = 3'd7
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_DET     = 3'd1;
    localparam logic [2:0] ERR_LOCK    = 3'd2;
    localparam logic [2:0] ERR_GAIN    = 3'd3;
    localparam logic [2:0] ERR_CAP     = 3'd4;
    localparam logic [2:0] ERR_RETRY   = 3'd5;
    localparam logic [2:0] ERR_ABORT   = 3'd6;

    // Counter values at which the last permitted cycle of each state is reached
    localparam logic [CNT_W-1:0] LOCK_LAST   = LOCK_TIMEOUT - CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = SETTLE_CYCLES - CNT_W'(1);
    localparam logic [CNT_W-1:0] CAP_LAST    = CAP_TIMEOUT - CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic [2:0]       err_reg, err_next;
    logic [1:0]       retry_reg, retry_next;
    logic             cap_start_reg, cap_start_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             in_busy_state;

    assign in_busy_state = (state_reg != IDLE) && (state_reg != DONE) && (state_reg != ERROR);
    assign cnt_inc       = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            err_reg       <= ERR_NONE;
            retry_reg     <= 2'd0;
            cap_start_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            err_reg       <= err_next;
            retry_reg     <= retry_next;
            cap_start_reg <= cap_start_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    // Next-state, counter and status
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_inc;
        err_next   = err_reg;
        retry_next = retry_reg;

        if (in_busy_state && abort) begin
            state_next = ERROR;
            err_next   = ERR_ABORT;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE, DONE, ERROR: begin
                    cnt_next = '0;
                    if (start) begin
                        state_next = WAIT_DET;
                        err_next   = ERR_NONE;
                        retry_next = 2'd0;
                    end
                end
                WAIT_DET: begin
                    if (freq_det_stable) begin
                        state_next = WAIT_LOCK;
                        cnt_next   = '0;
                    end else if (cnt_reg == LOCK_LAST) begin
                        state_next = ERROR;
                        err_next   = ERR_DET;
                        cnt_next   = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (!freq_det_stable) begin
                        state_next = WAIT_DET;
                        cnt_next   = '0;
                    end else if (freq_stable) begin
                        state_next = WAIT_GAIN;
                        cnt_next   = '0;
                    end else if (cnt_reg == LOCK_LAST) begin
                        state_next = ERROR;
                        err_next   = ERR_LOCK;
                        cnt_next   = '0;
                    end
                end
                WAIT_GAIN: begin
                    if (!freq_det_stable) begin
                        state_next = WAIT_DET;
                        cnt_next   = '0;
                    end else if (!freq_stable) begin
                        state_next = WAIT_LOCK;
                        cnt_next   = '0;
                    end else if (gain_stable) begin
                        state_next = SETTLE;
                        cnt_next   = '0;
                    end else if (cnt_reg == LOCK_LAST) begin
                        state_next = ERROR;
                        err_next   = ERR_GAIN;
                        cnt_next   = '0;
                    end
                end
                SETTLE: begin
                    if (!freq_det_stable) begin
                        state_next = WAIT_DET;
                        cnt_next   = '0;
                    end else if (!freq_stable) begin
                        state_next = WAIT_LOCK;
                        cnt_next   = '0;
                    end else if (!gain_stable) begin
                        state_next = WAIT_GAIN;
                        cnt_next   = '0;
                    end else if (cnt_reg == SETTLE_LAST) begin
                        state_next = CAPTURE;
                        cnt_next   = '0;
                    end
                end
                CAPTURE: begin
                    // cap_done outranks a simultaneous stability loss
                    if (cap_done) begin
                        state_next = DONE;
                        cnt_next   = '0;
                    end else if (!freq_stable || !gain_stable) begin
                        cnt_next = '0;
                        if (int'(retry_reg) < MAX_RETRY) begin
                            retry_next = retry_reg + 2'd1;
                            state_next = freq_det_stable ? WAIT_LOCK : WAIT_DET;
                        end else begin
                            state_next = ERROR;
                            err_next   = ERR_RETRY;
                        end
                    end else if (cnt_reg == CAP_LAST) begin
                        state_next = ERROR;
                        err_next   = ERR_CAP;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Output decode, registered one edge later alongside the state
    always_comb begin
        cap_start_next = (state_next == CAPTURE) && (state_reg != CAPTURE);
        busy_next      = (state_next != IDLE) && (state_next != DONE) && (state_next != ERROR);
        done_next      = (state_next == DONE);
    end

    assign cap_start = cap_start_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err_code  = err_reg;
    assign state_o   = state_reg;
    assign retry_cnt = retry_reg;

endmodule
